key_event_fifo: RTL and testbench
=================================

// Module: key_event_fifo
// PURPOSE
//   Downstream of the keypad strobe stage: on each strobe, priority-encodes the 20-bit key
//   vector (highest set index wins) into a 5-bit code and queues it in a small FIFO.
//   Consumers (game/UI logic) drain codes with a valid/ready handshake.
//   Overflow is flagged sticky; optional hold-to-repeat re-injects the held key.
// PARAMETERS
//   DEPTH         4        FIFO entries; power of two, >= 2
//   REPEAT_START  4000000  cycles a key is held before the first repeat (KEY_REPEAT_EN only)
//   REPEAT_CYC    1000000  cycles between later repeats (KEY_REPEAT_EN only)
// PORTS
//   clk        in   1                  system clock, all logic on posedge
//   rst        in   1                  reset, synchronous, active-high
//   keys       in   20                 key level vector, same as strobe stage's input
//   strobe     in   1                  1-cycle pulse from strobe stage: new press
//   code_ready in   1                  consumer accepts code_out this cycle
//   clr_ovf    in   1                  clears overflow
//   code_out   out  5                  head-of-FIFO key code 0..19
//   code_valid out  1                  FIFO not empty
//   count      out  $clog2(DEPTH)+1    entries held, 0..DEPTH
//   full       out  1                  count == DEPTH
//   overflow   out  1                  sticky: a push was dropped
// BEHAVIOUR
//   Reset: rd/wr ptrs, count=0, code_valid=0, full=0, overflow=0, code_out=0, FSM=IDLE.
//   Encode: code = index of highest set bit of keys; keys==0 at strobe -> no push, no flag.
//   Push request = (strobe & |keys) | repeat_push. Pop = code_valid & code_ready.
//   code_out = mem[rd_ptr] (comb from regs); 0 when empty. No fall-through.
//   Latency: strobe in cycle N -> code_valid=1 with code in N+1 (if FIFO was empty).
//   Push & pop same cycle: both happen, count unchanged; legal when full (slot freed).
//   Pop when empty: impossible (code_valid=0), code_ready ignored.
//   Push when full without pop: dropped, FIFO unchanged, overflow<=1 next cycle.
//   clr_ovf and a dropped push in same cycle: overflow stays 1 (set wins).
//   Pointers wrap modulo DEPTH; count saturates only by construction (never > DEPTH).
//   Storage is not cleared on reset; only pointers/count/flags.
// CONFIGURATION
//   KEY_REPEAT_EN defined: repeat FSM present.
//     IDLE  : accepted strobe -> held<=code, cnt<=REPEAT_START-1, HOLD.
//     HOLD  : keys==0 or encode(keys)!=held -> IDLE; cnt==0 -> repeat_push, cnt<=REPEAT_CYC-1,
//             REPEAT; else cnt--.
//     REPEAT: same exit rule as HOLD; cnt==0 -> repeat_push, reload REPEAT_CYC-1; else cnt--.
//     repeat_push obeys full/overflow rules; a dropped repeat still reloads cnt.
//     strobe in HOLD/REPEAT (release+repress between cycles): strobe wins, re-enter HOLD
//     with new code; no repeat_push that cycle. rst mid-hold -> IDLE, no push.
//   KEY_REPEAT_EN undefined: no FSM/counter; repeat_push tied 0; only strobes push.
// TESTING (DEPTH=4, REPEAT_START=8, REPEAT_CYC=4, code_ready=0 unless stated)
//   Reset: hold rst 2 cycles -> code_valid=0, count=0, full=0, overflow=0, code_out=0.
//   Priority: keys=20'h00012, strobe 1 cycle -> next cycle code_valid=1, code_out=4, count=1.
//   Order/fill: strobe keys bit3,7,0,19 -> count=4, full=1; pops via ready yield 3,7,0,19.
//   Overflow: full FIFO, strobe keys bit5 -> count stays 4, overflow=1; clr_ovf -> 0;
//     full + strobe + code_ready same cycle -> count 4, new tail=5, overflow stays 0.
//   Zero strobe: strobe with keys=0 -> no push, count unchanged, overflow=0.
//   Repeat (KEY_REPEAT_EN): hold bit9 after strobe 20 cycles -> pushes 9 at strobe+1,
//     +9, +13, +17 (count 4, full); release -> no further pushes; undefined -> one push only.

Source files
------------

// File: rtl/key_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : key_event_fifo
//  Purpose  : On each keypad strobe, priority-encodes the 20-bit key vector
//             (highest set index wins) into a 5-bit code and queues it in a
//             small FIFO. Consumers drain codes over a valid/ready handshake.
//             A dropped push sets a sticky overflow flag. With KEY_REPEAT_EN
//             defined, a hold-to-repeat FSM re-injects the held key code.
//  Ports    : clk, rst         clock, synchronous active-high reset
//             keys[19:0]       key level vector
//             strobe           1-cycle new-press pulse
//             code_ready       consumer accepts code_out this cycle
//             clr_ovf          clears overflow
//             code_out[4:0]    head-of-FIFO code (0 when empty)
//             code_valid       FIFO not empty
//             count            entries held, 0..DEPTH
//             full             count == DEPTH
//             overflow         sticky: a push was dropped
//  Config   : KEY_REPEAT_EN    define to build the hold-to-repeat FSM
//  Revision : 1.0  initial release
// ============================================================================
module key_event_fifo #(
   parameter int DEPTH        = 4,
   parameter int REPEAT_START = 4000000,
   parameter int REPEAT_CYC   = 1000000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [19:0]              keys,
   input  logic                     strobe,
   input  logic                     code_ready,
   input  logic                     clr_ovf,
   output logic [4:0]               code_out,
   output logic                     code_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     overflow
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int COUNT_W = PTR_W + 1;
   localparam logic [COUNT_W-1:0] C_DEPTH     = COUNT_W'(DEPTH);
   localparam logic [COUNT_W-1:0] C_COUNT_ONE = COUNT_W'(1);
   localparam logic [PTR_W-1:0]   C_PTR_ONE   = PTR_W'(1);

   logic [4:0]         r_mem [DEPTH];
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [COUNT_W-1:0] r_count;
   logic               r_overflow;

   logic [4:0]         w_code;
   logic               w_any_key;
   logic               w_strobe_ok;
   logic               w_repeat_push;
   logic [4:0]         w_push_code;
   logic               w_push_req;
   logic               w_push;
   logic               w_pop;
   logic               w_full;

   // Priority encoder: later (higher) indices overwrite earlier ones.
   always_comb begin
      w_code = 5'd0;
      for (int i = 0; i < 20; i++) begin
         if (keys[i]) w_code = 5'(i);
      end
   end

   assign w_any_key   = |keys;
   assign w_strobe_ok = strobe & w_any_key;

`ifdef KEY_REPEAT_EN
   localparam int CNT_MAX = (REPEAT_START > REPEAT_CYC) ? REPEAT_START : REPEAT_CYC;
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] C_START_LOAD = CNT_W'(REPEAT_START - 1);
   localparam logic [CNT_W-1:0] C_CYC_LOAD   = CNT_W'(REPEAT_CYC - 1);
   localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HOLD   = 2'd1,
      S_REPEAT = 2'd2
   } state_t;

   state_t           r_state, w_state_next;
   logic [4:0]       r_held, w_held_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_held  <= 5'd0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_held  <= w_held_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // A fresh strobe always restarts the hold timer, even mid-repeat, and
   // suppresses any repeat push in that cycle.
   always_comb begin
      w_state_next  = r_state;
      w_held_next   = r_held;
      w_cnt_next    = r_cnt;
      w_repeat_push = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_strobe_ok) begin
               w_state_next = S_HOLD;
               w_held_next  = w_code;
               w_cnt_next   = C_START_LOAD;
            end
         end
         S_HOLD, S_REPEAT: begin
            if (w_strobe_ok) begin
               w_state_next = S_HOLD;
               w_held_next  = w_code;
               w_cnt_next   = C_START_LOAD;
            end else if (!w_any_key || (w_code != r_held)) begin
               w_state_next = S_IDLE;
            end else if (r_cnt == '0) begin
               w_repeat_push = 1'b1;
               w_cnt_next    = C_CYC_LOAD;
               w_state_next  = S_REPEAT;
            end else begin
               w_cnt_next = r_cnt - C_CNT_ONE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign w_push_code = w_repeat_push ? r_held : w_code;
`else
   logic w_unused_cfg;
   assign w_unused_cfg  = (REPEAT_START > 0) ^ (REPEAT_CYC > 0);
   assign w_repeat_push = 1'b0;
   assign w_push_code   = w_code;
`endif

   assign w_full     = (r_count == C_DEPTH);
   assign code_valid = (r_count != '0);
   assign w_pop      = code_valid & code_ready;
   assign w_push_req = w_strobe_ok | w_repeat_push;
   // A simultaneous pop frees a slot, so a push into a full FIFO is legal then.
   assign w_push     = w_push_req & (~w_full | w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + C_COUNT_ONE;
            2'b01:   r_count <= r_count - C_COUNT_ONE;
            default: r_count <= r_count;
         endcase
         // Set has priority over clear.
         if (w_push_req && !w_push) r_overflow <= 1'b1;
         else if (clr_ovf)          r_overflow <= 1'b0;
      end
   end

   // Storage is deliberately not reset; only pointers and flags are.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_push_code;
   end

   assign code_out = code_valid ? r_mem[r_rd_ptr] : 5'd0;
   assign count    = r_count;
   assign full     = w_full;
   assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_key_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_event_fifo
//  Purpose  : Directed self-checking bench for key_event_fifo
//             (DEPTH=4, REPEAT_START=8, REPEAT_CYC=4). Honours KEY_REPEAT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_event_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic [19:0] keys;
   logic        strobe;
   logic        code_ready;
   logic        clr_ovf;
   logic [4:0]  code_out;
   logic        code_valid;
   logic [2:0]  count;
   logic        full;
   logic        overflow;

   int n_cmp = 0;
   int n_err = 0;

   key_event_fifo #(
      .DEPTH        (4),
      .REPEAT_START (8),
      .REPEAT_CYC   (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .keys       (keys),
      .strobe     (strobe),
      .code_ready (code_ready),
      .clr_ovf    (clr_ovf),
      .code_out   (code_out),
      .code_valid (code_valid),
      .count      (count),
      .full       (full),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input int bit_idx);
      keys   = 20'd1 << bit_idx;
      strobe = 1'b1;
      tick();
      strobe = 1'b0;
      keys   = 20'd0;
   endtask

   initial begin
      int exp_cnt;
      logic [4:0] exp_heads [4];
      int fill_bits [4];
      fill_bits = '{3, 7, 0, 19};
      exp_heads = '{5'd7, 5'd0, 5'd19, 5'd5};

      rst = 1'b1; keys = '0; strobe = 1'b0; code_ready = 1'b0; clr_ovf = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_valid",    32'(code_valid), 32'd0);
      chk("rst_count",    32'(count),      32'd0);
      chk("rst_full",     32'(full),       32'd0);
      chk("rst_overflow", 32'(overflow),   32'd0);
      chk("rst_code",     32'(code_out),   32'd0);

      // Priority: bits 1 and 4 set -> code 4
      keys = 20'h00012; strobe = 1'b1;
      tick();
      strobe = 1'b0; keys = '0;
      chk("prio_valid", 32'(code_valid), 32'd1);
      chk("prio_code",  32'(code_out),   32'd4);
      chk("prio_count", 32'(count),      32'd1);
      code_ready = 1'b1;
      tick();
      code_ready = 1'b0;
      chk("pop_empty_count", 32'(count),    32'd0);
      chk("pop_empty_code",  32'(code_out), 32'd0);

      // Fill in order 3,7,0,19
      foreach (fill_bits[i]) begin
         press(fill_bits[i]);
         tick();
      end
      chk("fill_count", 32'(count),    32'd4);
      chk("fill_full",  32'(full),     32'd1);
      chk("fill_head",  32'(code_out), 32'd3);

      // Dropped push when full
      press(5);
      chk("ovf_count", 32'(count),    32'd4);
      chk("ovf_flag",  32'(overflow), 32'd1);
      chk("ovf_head",  32'(code_out), 32'd3);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("ovf_clear", 32'(overflow), 32'd0);

      // Full + strobe + pop: both succeed, 5 becomes tail
      keys = 20'd1 << 5; strobe = 1'b1; code_ready = 1'b1;
      tick();
      keys = '0; strobe = 1'b0; code_ready = 1'b0;
      chk("pushpop_count", 32'(count),    32'd4);
      chk("pushpop_ovf",   32'(overflow), 32'd0);

      // Drain: expect 7,0,19,5
      foreach (exp_heads[i]) begin
         chk($sformatf("drain_head%0d", i), 32'(code_out), 32'(exp_heads[i]));
         code_ready = 1'b1;
         tick();
         code_ready = 1'b0;
      end
      chk("drain_valid", 32'(code_valid), 32'd0);

      // Zero-key strobe: nothing pushed, no flag
      keys = '0; strobe = 1'b1;
      tick();
      strobe = 1'b0;
      chk("zero_count", 32'(count),    32'd0);
      chk("zero_ovf",   32'(overflow), 32'd0);

      // Hold bit 9 for 20 cycles after the strobe
      keys = 20'd1 << 9; strobe = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         strobe = 1'b0;
`ifdef KEY_REPEAT_EN
         exp_cnt = (k >= 16) ? 4 : (k >= 12) ? 3 : (k >= 8) ? 2 : 1;
`else
         exp_cnt = 1;
`endif
         chk($sformatf("hold_count_k%0d", k), 32'(count), 32'(exp_cnt));
      end
      chk("hold_head", 32'(code_out), 32'd9);
      keys = '0;
      for (int k = 0; k < 10; k++) tick();
`ifdef KEY_REPEAT_EN
      exp_cnt = 4;
`else
      exp_cnt = 1;
`endif
      chk("release_count", 32'(count),    32'(exp_cnt));
      chk("release_ovf",   32'(overflow), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
